mips_mc_ctrl: RTL and testbench

Multicycle control FSM for the MIPS datapath. It sequences the shared 32-bit ALU, memory port, register file and PC through fetch, decode, execute, memory and writeback phases. It decodes `opcode`/`funct` into the 4-bit `aluCode` consumed by the ALU and uses the ALU zero flag to resolve branches. Memory accesses are paced by a ready handshake.

---
 rtl/mips_mc_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
// Multicycle control FSM for the MIPS datapath. It sequences the shared ALU,
// memory port, register file and PC through fetch, decode, execute, memory
// and writeback. It decodes opcode/funct into the 4-bit ALU operation code and
// uses the ALU zero flag to resolve branches. Memory accesses wait on
// mem_ready.
//
// Optional feature macro: MIPS_MC_CTRL_BNE_EN
//   defined     -> opcode 000101 (bne) is executed through BRANCH
//   not defined -> opcode 000101 is treated as illegal
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   IR[31:26], held stable after ir_write
//   funct      in   IR[5:0]
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes the current access this cycle
//   mem_read   out  memory read strobe
//   mem_write  out  memory write strobe
//   i_or_d     out  0 = PC address, 1 = ALUOut address
//   ir_write   out  load IR
//   pc_en      out  load PC
//   pc_source  out  00 ALU result, 01 ALUOut, 10 jump target
//   alu_src_a  out  0 = PC, 1 = reg A
//   alu_src_b  out  00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   aluCode    out  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//   reg_write  out  register file write enable
//   reg_dst    out  0 = rt, 1 = rd
//   mem_to_reg out  0 = ALUOut, 1 = memory data
//   retire     out  one-cycle pulse in the final state of a legal instruction
//   illegal    out  sticky flag, cleared only by reset
//   state      out  current state encoding (debug)
// ---------------------------------------------------------------------------
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] aluCode,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // Ungated decode of the current state; gated by rst_n at the ports.
    logic       mem_read_c, mem_write_c, i_or_d_c, ir_write_c, pc_en_c;
    logic [1:0] pc_source_c, alu_src_b_c;
    logic       alu_src_a_c, reg_write_c, reg_dst_c, mem_to_reg_c, retire_c;
    logic [3:0] alu_code_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        i_or_d_c     = 1'b0;
        ir_write_c   = 1'b0;
        pc_en_c      = 1'b0;
        pc_source_c  = 2'b00;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_code_c   = ALU_ADD;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        retire_c     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle but only latched when the
                // instruction word actually arrives.
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = mem_ready;
                pc_en_c     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                alu_src_b_c = 2'b11;
                unique case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
`ifdef MIPS_MC_CTRL_BNE_EN
                    OP_BNE:        state_d = S_BRANCH;
`endif
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                i_or_d_c   = 1'b1;
                mem_read_c = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                // A store retires in the cycle its write completes.
                i_or_d_c    = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                state_d     = S_R_WB;
                unique case (funct)
                    6'b100000: alu_code_c = ALU_ADD;
                    6'b100010: alu_code_c = ALU_SUB;
                    6'b100100: alu_code_c = ALU_AND;
                    6'b100101: alu_code_c = ALU_OR;
                    6'b101010: alu_code_c = ALU_SLT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_code_c  = ALU_SUB;
                pc_source_c = 2'b01;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
`ifdef MIPS_MC_CTRL_BNE_EN
                pc_en_c     = (opcode == OP_BNE) ? ~zero : zero;
`else
                pc_en_c     = zero;
`endif
            end
            S_JUMP: begin
                pc_source_c = 2'b10;
                pc_en_c     = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // While reset is held every control line is forced inactive so a
    // memory access in flight is dropped immediately.
    assign mem_read   = rst_n & mem_read_c;
    assign mem_write  = rst_n & mem_write_c;
    assign i_or_d     = rst_n & i_or_d_c;
    assign ir_write   = rst_n & ir_write_c;
    assign pc_en      = rst_n & pc_en_c;
    assign pc_source  = rst_n ? pc_source_c : 2'b00;
    assign alu_src_a  = rst_n & alu_src_a_c;
    assign alu_src_b  = rst_n ? alu_src_b_c : 2'b00;
    assign aluCode    = rst_n ? alu_code_c : ALU_ADD;
    assign reg_write  = rst_n & reg_write_c;
    assign reg_dst    = rst_n & reg_dst_c;
    assign mem_to_reg = rst_n & mem_to_reg_c;
    assign retire     = rst_n & retire_c;
    assign illegal    = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Directed self-checking bench for the multicycle MIPS control FSM. Each
// instruction is walked cycle by cycle with hand-computed expected outputs.
// ---------------------------------------------------------------------------
module tb_mips_mc_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, retire, illegal;
    logic [3:0] aluCode, state;

    int checkCount = 0;
    int failCount  = 0;

    mips_mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluCode    (aluCode),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .retire     (retire),
        .illegal    (illegal),
        .state      (state)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive all datapath-facing inputs, then let the outputs settle
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic mr);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        #1;
    endtask

    // Hold reset for two edges and release it between edges
    task automatic pulseReset();
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        #1;
    endtask

    // Walk FETCH and DECODE with mem_ready high, ending in the third state
    task automatic fetchDecode(input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
        applyStimulus(op, fn, z, 1'b1);
        nextCycle();
        nextCycle();
    endtask

    // Hard stop in case anything stalls the directed sequence
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        failCount++;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #1;

        // Reset state: strobes forced low, add code, FETCH
        nextCycle();
        checkOutput("rst_state",    state,    4'd0);
        checkOutput("rst_mem_read", mem_read, 1'b0);
        checkOutput("rst_aluCode",  aluCode,  4'b0010);
        checkOutput("rst_illegal",  illegal,  1'b0);
        nextCycle();
        rst_n = 1'b1;
        #1;

        // lw with two wait cycles in FETCH
        applyStimulus(6'b100011, 6'd0, 1'b0, 1'b0);
        checkOutput("lw_f0_state",    state,     4'd0);
        checkOutput("lw_f0_mem_read", mem_read,  1'b1);
        checkOutput("lw_f0_ir_write", ir_write,  1'b0);
        checkOutput("lw_f0_srcb",     alu_src_b, 2'b01);
        nextCycle();
        checkOutput("lw_f1_state",    state,     4'd0);
        checkOutput("lw_f1_pc_en",    pc_en,     1'b0);
        nextCycle();
        applyStimulus(6'b100011, 6'd0, 1'b0, 1'b1);
        checkOutput("lw_f2_state",    state,     4'd0);
        checkOutput("lw_f2_ir_write", ir_write,  1'b1);
        checkOutput("lw_f2_pc_en",    pc_en,     1'b1);
        nextCycle();
        checkOutput("lw_dec_state",   state,     4'd1);
        checkOutput("lw_dec_srcb",    alu_src_b, 2'b11);
        checkOutput("lw_dec_ir_write",ir_write,  1'b0);
        nextCycle();
        checkOutput("lw_addr_state",  state,     4'd2);
        checkOutput("lw_addr_srca",   alu_src_a, 1'b1);
        checkOutput("lw_addr_srcb",   alu_src_b, 2'b10);
        nextCycle();
        checkOutput("lw_rd_state",    state,     4'd3);
        checkOutput("lw_rd_i_or_d",   i_or_d,    1'b1);
        checkOutput("lw_rd_mem_read", mem_read,  1'b1);
        nextCycle();
        checkOutput("lw_wb_state",    state,     4'd4);
        checkOutput("lw_wb_reg_write",reg_write, 1'b1);
        checkOutput("lw_wb_mem2reg",  mem_to_reg,1'b1);
        checkOutput("lw_wb_retire",   retire,    1'b1);
        nextCycle();
        checkOutput("lw_end_state",   state,     4'd0);

        // R-type slt: 4 cycles total
        fetchDecode(6'b000000, 6'b101010, 1'b0);
        checkOutput("slt_ex_state",   state,     4'd6);
        checkOutput("slt_ex_aluCode", aluCode,   4'b0111);
        checkOutput("slt_ex_srcb",    alu_src_b, 2'b00);
        nextCycle();
        checkOutput("slt_wb_state",   state,     4'd7);
        checkOutput("slt_wb_reg_dst", reg_dst,   1'b1);
        checkOutput("slt_wb_reg_write",reg_write,1'b1);
        checkOutput("slt_wb_retire",  retire,    1'b1);
        nextCycle();
        checkOutput("slt_end_state",  state,     4'd0);

        // R-type sub decode
        fetchDecode(6'b000000, 6'b100010, 1'b0);
        checkOutput("sub_aluCode",    aluCode,   4'b0110);
        nextCycle();
        nextCycle();

        // beq taken
        fetchDecode(6'b000100, 6'd0, 1'b1);
        checkOutput("beq1_state",     state,     4'd8);
        checkOutput("beq1_pc_en",     pc_en,     1'b1);
        checkOutput("beq1_pc_source", pc_source, 2'b01);
        checkOutput("beq1_aluCode",   aluCode,   4'b0110);
        checkOutput("beq1_retire",    retire,    1'b1);
        nextCycle();
        checkOutput("beq1_end_state", state,     4'd0);

        // beq not taken
        fetchDecode(6'b000100, 6'd0, 1'b0);
        checkOutput("beq0_pc_en",     pc_en,     1'b0);
        checkOutput("beq0_retire",    retire,    1'b1);
        nextCycle();

        // j
        fetchDecode(6'b000010, 6'd0, 1'b0);
        checkOutput("j_state",        state,     4'd9);
        checkOutput("j_pc_source",    pc_source, 2'b10);
        checkOutput("j_pc_en",        pc_en,     1'b1);
        nextCycle();
        checkOutput("j_end_state",    state,     4'd0);

        // addi
        fetchDecode(6'b001000, 6'd0, 1'b0);
        checkOutput("addi_ex_state",  state,     4'd10);
        checkOutput("addi_ex_srcb",   alu_src_b, 2'b10);
        nextCycle();
        checkOutput("addi_wb_state",  state,     4'd11);
        checkOutput("addi_wb_reg_write",reg_write,1'b1);
        checkOutput("addi_wb_reg_dst",reg_dst,   1'b0);
        checkOutput("addi_wb_retire", retire,    1'b1);
        nextCycle();
        checkOutput("addi_illegal",   illegal,   1'b0);

        // bne with zero=0
        fetchDecode(6'b000101, 6'd0, 1'b0);
`ifdef MIPS_MC_CTRL_BNE_EN
        checkOutput("bne_state",      state,     4'd8);
        checkOutput("bne_pc_en",      pc_en,     1'b1);
        checkOutput("bne_illegal",    illegal,   1'b0);
        nextCycle();
`else
        checkOutput("bne_state",      state,     4'd0);
        checkOutput("bne_illegal",    illegal,   1'b1);
`endif
        pulseReset();
        checkOutput("rst2_illegal",   illegal,   1'b0);

        // Illegal opcode: 2 cycles, sticky through a following sw
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("ill_dec_state",  state,     4'd1);
        checkOutput("ill_dec_illegal",illegal,   1'b0);
        nextCycle();
        checkOutput("ill_end_state",  state,     4'd0);
        checkOutput("ill_illegal",    illegal,   1'b1);
        fetchDecode(6'b101011, 6'd0, 1'b0);
        checkOutput("sw_addr_state",  state,     4'd2);
        nextCycle();
        checkOutput("sw_wr_state",    state,     4'd5);
        checkOutput("sw_wr_mem_write",mem_write, 1'b1);
        checkOutput("sw_wr_i_or_d",   i_or_d,    1'b1);
        checkOutput("sw_wr_retire",   retire,    1'b1);
        nextCycle();
        checkOutput("sw_end_state",   state,     4'd0);
        checkOutput("sw_illegal",     illegal,   1'b1);

        // Illegal funct: EXEC returns to FETCH without writeback
        fetchDecode(6'b000000, 6'b000111, 1'b0);
        checkOutput("badfn_ex_state", state,     4'd6);
        checkOutput("badfn_ex_retire",retire,    1'b0);
        nextCycle();
        checkOutput("badfn_end_state",state,     4'd0);
        checkOutput("badfn_reg_write",reg_write, 1'b0);

        // sw stalled in MEM_WR, then reset mid-access
        fetchDecode(6'b101011, 6'd0, 1'b0);
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("swr_wr_state",   state,     4'd5);
        checkOutput("swr_wr_retire",  retire,    1'b0);
        nextCycle();
        checkOutput("swr_hold_state", state,     4'd5);
        checkOutput("swr_hold_mem_write",mem_write,1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("swr_rst_mem_write",mem_write,1'b0);
        checkOutput("swr_rst_i_or_d", i_or_d,    1'b0);
        checkOutput("swr_rst_state",  state,     4'd0);
        checkOutput("swr_rst_retire", retire,    1'b0);
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("swr_rel_state",  state,     4'd0);
        checkOutput("swr_rel_illegal",illegal,   1'b0);
        checkOutput("swr_rel_retire", retire,    1'b0);
        checkOutput("swr_rel_mem_read",mem_read, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
